mips_prog_loader: RTL and testbench

//  Upstream program loader for the 32-bit pipelined MIPS core. Accepts a byte stream from a host,

---
 rtl/mips_prog_loader_pkg.sv | 23 ++
 rtl/mips_prog_loader_if.sv | 11 +
 rtl/mips_prog_loader_word_pack.sv | 37 +++
 rtl/mips_prog_loader.sv | 141 ++++++++++++++
 tb/tb_mips_prog_loader.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_prog_loader_pkg.sv
// Shared types and constants for the MIPS program loader.
package mips_loader_pkg;

  localparam int HDR_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  typedef enum logic [2:0] {
    H_ADDR_HI,
    H_ADDR_LO,
    H_CNT_HI,
    H_CNT_LO,
    PAYLOAD,
    CSUM,
    START
  } state_t;

  // Total bytes on the wire for a frame carrying cnt words.
  function automatic int frame_bytes(input logic [15:0] cnt, input bit with_csum);
    return HDR_BYTES + BYTES_PER_WORD * int'(cnt) + (with_csum ? 1 : 0);
  endfunction

endpackage

// File: rtl/mips_prog_loader_if.sv
// Host byte-stream channel: valid/ready handshake, one byte per transfer.
interface mips_prog_loader_if;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/mips_prog_loader_word_pack.sv
// Packs accepted payload bytes MSB first into 32-bit words; word_valid is a one-cycle pulse.
module loader_word_pack
  import mips_loader_pkg::*;
(
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_done,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]        byte_cnt;
  logic [WORD_W-9:0] shift;

  // Combinational: the byte being accepted right now completes a word.
  assign word_done = byte_valid && (byte_cnt == 2'(BYTES_PER_WORD - 1));

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt   <= '0;
      shift      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= word_done;
      if (byte_valid) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift    <= {shift[WORD_W-17:0], byte_data};
        if (word_done) word <= {shift, byte_data};
      end
    end
  end

endmodule

// File: rtl/mips_prog_loader.sv
// Program loader for the pipelined MIPS core: parses a framed byte stream, writes words, starts the core.
// Define MIPS_LOADER_CHECKSUM_EN to require and verify a trailing XOR checksum byte per frame.
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                clk1,
  input  logic                rst_n,
  mips_prog_loader_if.slave   host,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic                cpu_halt,
  output logic                cpu_start,
  output logic [ADDR_W-1:0]   start_pc,
  output logic                busy,
  output logic                err
);

`ifdef MIPS_LOADER_CHECKSUM_EN
  localparam state_t POST_DATA = CSUM;
`else
  localparam state_t POST_DATA = START;
`endif

  state_t            state, state_nx;
  logic              accept;
  logic              payload_byte;
  logic              word_done;
  logic              last_word;
  logic [7:0]        addr_hi;
  logic [7:0]        cnt_hi;
  logic [15:0]       words_left;
  logic [ADDR_W-1:0] load_addr;

`ifdef MIPS_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_bad;
  logic       err_q;
`endif

  assign host.s_ready = (state != START);
  assign accept       = host.s_valid && host.s_ready;
  assign payload_byte = accept && (state == PAYLOAD);
  assign last_word    = word_done && (words_left == 16'd1);
  assign cpu_start    = (state == START);
  assign start_pc     = load_addr;

  loader_word_pack u_pack (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .byte_valid (payload_byte),
    .byte_data  (host.s_data),
    .word_done  (word_done),
    .word_valid (mem_we),
    .word       (mem_wdata)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state <= H_ADDR_HI;
    else        state <= state_nx;
  end

  // NOTE: state_nx gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      H_ADDR_HI: if (accept) state_nx = H_ADDR_LO;
      H_ADDR_LO: if (accept) state_nx = H_CNT_HI;
      H_CNT_HI:  if (accept) state_nx = H_CNT_LO;
      H_CNT_LO:  if (accept) state_nx = ({cnt_hi, host.s_data} == 16'd0) ? POST_DATA : PAYLOAD;
      PAYLOAD:   if (last_word) state_nx = POST_DATA;
`ifdef MIPS_LOADER_CHECKSUM_EN
      CSUM:      if (accept) state_nx = csum_bad ? H_ADDR_HI : START;
`endif
      START:     state_nx = H_ADDR_HI;
      default:   state_nx = H_ADDR_HI;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      addr_hi    <= '0;
      cnt_hi     <= '0;
      words_left <= '0;
      load_addr  <= '0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      cpu_halt   <= 1'b1;
    end else begin
      if (accept && state == H_ADDR_HI) begin
        addr_hi  <= host.s_data;
        busy     <= 1'b1;
        cpu_halt <= 1'b1;
      end
      if (accept && state == H_ADDR_LO) load_addr <= ADDR_W'({addr_hi, host.s_data});
      if (accept && state == H_CNT_HI)  cnt_hi    <= host.s_data;
      if (accept && state == H_CNT_LO) begin
        words_left <= {cnt_hi, host.s_data};
        mem_addr   <= load_addr;
      end
      if (word_done) words_left <= words_left - 16'd1;
      // Address steps after each write strobe, wrapping naturally at 2^ADDR_W.
      if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
      if (state_nx == START) begin
        busy     <= 1'b0;
        cpu_halt <= 1'b0;
      end
`ifdef MIPS_LOADER_CHECKSUM_EN
      if (accept && state == CSUM && csum_bad) busy <= 1'b0;
`endif
    end
  end

`ifdef MIPS_LOADER_CHECKSUM_EN
  assign csum_bad = (host.s_data != csum);

  // Running XOR restarts with the first header byte; err is sticky until the next frame begins.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      if (state == H_ADDR_HI) begin
        csum  <= host.s_data;
        err_q <= 1'b0;
      end else if (state == CSUM) begin
        if (csum_bad) err_q <= 1'b1;
      end else begin
        csum <= csum ^ host.s_data;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_prog_loader.sv
// Self-checking bench for mips_prog_loader: directed frame table, random frames, mid-frame reset, checksum.
module tb_mips_prog_loader;
  import mips_loader_pkg::*;

  localparam int ADDR_W = 10;
  localparam int AMOD   = 1 << ADDR_W;

  typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic [ADDR_W-1:0] pc; int cyc; } st_t;
  typedef struct {
    logic [15:0]       addr;
    int                cnt;
    logic [31:0]       w [3];
    int                gap;
    logic [ADDR_W-1:0] exp_pc;
    logic [ADDR_W-1:0] exp_last;
  } vec_t;

  logic              clk1 = 1'b0;
  logic              rst_n;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_halt;
  logic              cpu_start;
  logic [ADDR_W-1:0] start_pc;
  logic              busy;
  logic              err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  wr_t         wr_q[$];
  st_t         st_q[$];
  logic [31:0] fw[$];

  mips_prog_loader_if host();

  mips_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .host      (host),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_halt  (cpu_halt),
    .cpu_start (cpu_start),
    .start_pc  (start_pc),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk1 = ~clk1;

  always @(posedge clk1) cyc <= cyc + 1;

  always @(negedge clk1) begin
    if (rst_n === 1'b1) begin
      if (mem_we)    wr_q.push_back('{mem_addr, mem_wdata, cyc});
      if (cpu_start) st_q.push_back('{start_pc, cyc});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".s_ready"},   32'(host.s_ready), 32'd1);
    check({tag, ".mem_we"},    32'(mem_we),       32'd0);
    check({tag, ".cpu_start"}, 32'(cpu_start),    32'd0);
    check({tag, ".cpu_halt"},  32'(cpu_halt),     32'd1);
    check({tag, ".busy"},      32'(busy),         32'd0);
    check({tag, ".err"},       32'(err),          32'd0);
    check({tag, ".mem_addr"},  32'(mem_addr),     32'd0);
    check({tag, ".mem_wdata"}, mem_wdata,         32'd0);
    check({tag, ".start_pc"},  32'(start_pc),     32'd0);
  endtask

  // Present one byte (after optional random idle cycles) and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int   budget;
    logic rdy;
    while (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
      host.s_valid = 1'b0;
      @(posedge clk1); #1;
    end
    host.s_data  = b;
    host.s_valid = 1'b1;
    budget = 20;
    forever begin
      rdy = host.s_ready;
      @(posedge clk1); #1;
      if (rdy) break;
      budget--;
      if (budget == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL byte_accept: got no acceptance in 20 cycles, required acceptance");
        break;
      end
    end
    host.s_valid = 1'b0;
  endtask

  // Send a frame carrying the words in fw and compare writes/start against the frame's meaning.
  task automatic run_frame(input logic [15:0] addr, input int gap_pct, input bit corrupt, input string tag);
    logic [7:0]  bytes[$];
    logic [7:0]  cs;
    logic [15:0] cnt16;
    int          exp_pc;
    exp_pc = int'(addr) % AMOD;
    cnt16  = 16'(fw.size());
    bytes.push_back(addr[15:8]);
    bytes.push_back(addr[7:0]);
    bytes.push_back(cnt16[15:8]);
    bytes.push_back(cnt16[7:0]);
    foreach (fw[i]) for (int k = 3; k >= 0; k--) bytes.push_back(fw[i][8*k +: 8]);
    cs = 8'h00;
    foreach (bytes[i]) cs ^= bytes[i];
`ifdef MIPS_LOADER_CHECKSUM_EN
    bytes.push_back(corrupt ? (cs ^ 8'h01) : cs);
`endif
    wr_q.delete();
    st_q.delete();
    foreach (bytes[i]) begin
      send_byte(bytes[i], gap_pct);
      if (i == 0) begin
        check({tag, ".busy_first"}, 32'(busy),     32'd1);
        check({tag, ".halt_first"}, 32'(cpu_halt), 32'd1);
        check({tag, ".err_first"},  32'(err),      32'd0);
      end
    end
    if (corrupt) begin
      repeat (3) @(posedge clk1);
      #1;
      check({tag, ".err"},      32'(err),         32'd1);
      check({tag, ".cpu_halt"}, 32'(cpu_halt),    32'd1);
      check({tag, ".busy"},     32'(busy),        32'd0);
      check({tag, ".starts"},   32'(st_q.size()), 32'd0);
    end else begin
      check({tag, ".cpu_start"}, 32'(cpu_start),    32'd1);
      check({tag, ".start_pc"},  32'(start_pc),     32'(exp_pc));
      check({tag, ".cpu_halt"},  32'(cpu_halt),     32'd0);
      check({tag, ".busy"},      32'(busy),         32'd0);
      check({tag, ".s_ready"},   32'(host.s_ready), 32'd0);
      @(posedge clk1); #1;
      check({tag, ".start_end"}, 32'(cpu_start),    32'd0);
      check({tag, ".ready_back"},32'(host.s_ready), 32'd1);
      repeat (2) @(posedge clk1);
      #1;
      check({tag, ".starts"}, 32'(st_q.size()), 32'd1);
      check({tag, ".nwrites"}, 32'(wr_q.size()), 32'(fw.size()));
      check({tag, ".err"}, 32'(err), 32'd0);
      foreach (wr_q[i]) begin
        if (i < fw.size()) begin
          check($sformatf("%s.addr%0d", tag, i), 32'(wr_q[i].addr), 32'((exp_pc + i) % AMOD));
          check($sformatf("%s.data%0d", tag, i), wr_q[i].data, fw[i]);
        end
        if (st_q.size() > 0)
          check($sformatf("%s.order%0d", tag, i), 32'(wr_q[i].cyc <= st_q[0].cyc), 32'd1);
      end
    end
  endtask

  function automatic vec_t mk(input logic [15:0] a, input int c,
                              input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                              input int g, input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] last);
    vec_t v;
    v.addr = a; v.cnt = c; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
    v.gap = g; v.exp_pc = pc; v.exp_last = last;
    return v;
  endfunction

  initial begin
    vec_t vecs[5];
    int   n;

    rst_n        = 1'b0;
    host.s_valid = 1'b0;
    host.s_data  = 8'h00;
    repeat (2) @(posedge clk1);
    #1;
    check_reset("reset");
    @(negedge clk1) rst_n = 1'b1;
    @(posedge clk1); #1;

    vecs[0] = mk(16'h0000, 2, 32'h28010040, 32'h0C631800, 32'h0, 0,  10'h000, 10'h001);
    vecs[1] = mk(16'h0040, 0, 32'h0,        32'h0,        32'h0, 0,  10'h040, 10'h040);
    vecs[2] = mk(16'h03FF, 2, 32'hDEADBEEF, 32'h0BADF00D, 32'h0, 0,  10'h3FF, 10'h000);
    vecs[3] = mk(16'hFC05, 3, 32'h11223344, 32'h55667788, 32'h99AABBCC, 0, 10'h005, 10'h007);
    vecs[4] = mk(16'h0000, 2, 32'h28010040, 32'h0C631800, 32'h0, 40, 10'h000, 10'h001);

    for (int v = 0; v < 5; v++) begin
      fw.delete();
      for (int i = 0; i < vecs[v].cnt; i++) fw.push_back(vecs[v].w[i]);
      run_frame(vecs[v].addr, vecs[v].gap, 1'b0, $sformatf("vec%0d", v));
      if (st_q.size() > 0)
        check($sformatf("vec%0d.tbl_pc", v), 32'(st_q[0].pc), 32'(vecs[v].exp_pc));
      if (vecs[v].cnt > 0 && wr_q.size() > 0) begin
        check($sformatf("vec%0d.tbl_first", v), 32'(wr_q[0].addr), 32'(vecs[v].exp_pc));
        check($sformatf("vec%0d.tbl_last", v), 32'(wr_q[wr_q.size()-1].addr), 32'(vecs[v].exp_last));
      end
    end

    for (int r = 0; r < 15; r++) begin
      fw.delete();
      n = int'($urandom_range(4, 0));
      for (int i = 0; i < n; i++) fw.push_back($urandom());
      run_frame(16'($urandom()), int'($urandom_range(50, 0)), 1'b0, $sformatf("rnd%0d", r));
    end

    // Reset after the header and 5 payload bytes of a 2-word frame at 0x100.
    wr_q.delete();
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
    for (int i = 0; i < 5; i++) send_byte(8'hA1 + 8'(i), 0);
    check("midrst.partial_writes", 32'(wr_q.size()), 32'd1);
    rst_n = 1'b0;
    #2;
    check_reset("midrst");
    @(negedge clk1) rst_n = 1'b1;
    @(posedge clk1); #1;
    fw.delete();
    fw.push_back(32'h28010040);
    fw.push_back(32'h0C631800);
    run_frame(16'h0200, 0, 1'b0, "post_rst");

`ifdef MIPS_LOADER_CHECKSUM_EN
    run_frame(16'h0000, 0, 1'b1, "bad_csum");
    run_frame(16'h0000, 0, 1'b0, "good_after_bad");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
